// File: rtl/mem_arbiter.sv
// mem_arbiter: owns the single shared main-memory port for the pipelined cpu.
// It grants one of three requesters per operation (D write-through, D-cache
// miss, I-cache miss), in that fixed priority order. A miss fetches a whole
// block with back-to-back pipelined reads, streams the returning words into
// the selected cache data array, then writes the tag and pulses done. A write
// is a single one-cycle memory write acknowledged with d_wr_ack.
//
// Ports:
//   clk, rst                     clock (rising edge), synchronous active-high reset
//   i_miss, i_miss_addr          I-cache miss request (level) and byte address
//   d_miss, d_miss_addr          D-cache miss request (level) and byte address
//   d_wr, d_wr_addr, d_wr_data   D write-through request, address and data
//   mem_en, mem_wr, mem_addr,
//   mem_wdata                    memory command port
//   mem_rdata, mem_valid         memory read return
//   fill_we, fill_sel,
//   fill_word, fill_data         cache data-array fill port
//   tag_we, tag_addr             cache tag write at the end of a fill
//   i_done, d_done, d_wr_ack     completion pulses
//   busy                         high whenever the arbiter is not idle
//
// State table:
//   DRAIN | after reset, wait out reads still in flight (mem_valid ignored)
//   IDLE  | sample requests, latch the winner
//   WRITE | one-cycle memory write plus ack
//   FILL  | issue block reads, collect returns into the cache
//   DONE  | tag write and done pulse

module mem_arbiter #(
    parameter int MEM_LAT   = 4,
    parameter int BLK_WORDS = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_miss,
    input  logic [15:0]                  i_miss_addr,
    input  logic                         d_miss,
    input  logic [15:0]                  d_miss_addr,
    input  logic                         d_wr,
    input  logic [15:0]                  d_wr_addr,
    input  logic [15:0]                  d_wr_data,
    output logic                         mem_en,
    output logic                         mem_wr,
    output logic [15:0]                  mem_addr,
    output logic [15:0]                  mem_wdata,
    input  logic [15:0]                  mem_rdata,
    input  logic                         mem_valid,
    output logic                         fill_we,
    output logic                         fill_sel,
    output logic [$clog2(BLK_WORDS)-1:0] fill_word,
    output logic [15:0]                  fill_data,
    output logic                         tag_we,
    output logic [15:0]                  tag_addr,
    output logic                         i_done,
    output logic                         d_done,
    output logic                         d_wr_ack,
    output logic                         busy
);

    localparam int          WB       = $clog2(BLK_WORDS);
    localparam logic [15:0] BLK_MASK = ~16'(2 * BLK_WORDS - 1);

    typedef enum logic [2:0] {DRAIN, IDLE, WRITE, FILL, DONE} state_t;

    state_t          state;
    logic [7:0]      drain_cnt;
    logic [WB:0]     issue_cnt;   // extra top bit marks "all reads issued"
    logic [WB-1:0]   recv_cnt;
    logic [15:0]     base;
    logic [15:0]     wr_addr;
    logic [15:0]     wr_data;
    logic            sel;
    logic            issuing;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= DRAIN;
            drain_cnt <= 8'(MEM_LAT);
            issue_cnt <= '0;
            recv_cnt  <= '0;
            base      <= '0;
            wr_addr   <= '0;
            wr_data   <= '0;
            sel       <= 1'b0;
        end else begin
            case (state)
                DRAIN: begin
                    // The count is loaded with MEM_LAT, so exactly MEM_LAT
                    // cycles are spent here.
                    if (drain_cnt <= 8'd1) begin
                        drain_cnt <= '0;
                        state     <= IDLE;
                    end else begin
                        drain_cnt <= drain_cnt - 8'd1;
                    end
                end
                IDLE: begin
                    issue_cnt <= '0;
                    recv_cnt  <= '0;
                    if (d_wr) begin
                        wr_addr <= d_wr_addr;
                        wr_data <= d_wr_data;
                        state   <= WRITE;
                    end else if (d_miss) begin
                        base  <= d_miss_addr & BLK_MASK;
                        sel   <= 1'b1;
                        state <= FILL;
                    end else if (i_miss) begin
                        base  <= i_miss_addr & BLK_MASK;
                        sel   <= 1'b0;
                        state <= FILL;
                    end
                end
                WRITE: begin
                    state <= IDLE;
                end
                FILL: begin
                    if (issuing) begin
                        issue_cnt <= issue_cnt + 1'b1;
                    end
                    if (mem_valid) begin
                        recv_cnt <= recv_cnt + 1'b1;
                        if (&recv_cnt) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= DRAIN;
                end
            endcase
        end
    end

    assign issuing = (state == FILL) && !issue_cnt[WB];

    // Word offset is OR-ed into the aligned base so the address never carries
    // out of the block.
    assign mem_en    = (state == WRITE) || issuing;
    assign mem_wr    = (state == WRITE);
    assign mem_addr  = (state == WRITE) ? wr_addr :
                       issuing          ? (base | 16'({issue_cnt[WB-1:0], 1'b0})) :
                                          16'h0000;
    assign mem_wdata = (state == WRITE) ? wr_data : 16'h0000;

    assign fill_we   = (state == FILL) && mem_valid;
    assign fill_sel  = sel;
    assign fill_word = (state == FILL) ? recv_cnt : '0;
    assign fill_data = mem_rdata;

    assign tag_we    = (state == DONE);
    assign tag_addr  = (state == DONE) ? base : 16'h0000;
    assign i_done    = (state == DONE) && !sel;
    assign d_done    = (state == DONE) && sel;
    assign d_wr_ack  = (state == WRITE);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios followed by a randomized run.
// Expected port values come from a transaction-level model: when the model
// sees a grant at edge N it derives every output of the following cycles from
// the offset k = cycle - N (issue window, return window, done cycle).
// A small latency-accurate memory answers the DUT's reads.

module tb_mem_arbiter;

    localparam int LAT = 4;
    localparam int BLK = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_miss = 1'b0, d_miss = 1'b0, d_wr = 1'b0;
    logic [15:0] i_miss_addr = '0, d_miss_addr = '0, d_wr_addr = '0, d_wr_data = '0;
    logic        mem_en, mem_wr;
    logic [15:0] mem_addr, mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        mem_valid = 1'b0;
    logic        fill_we, fill_sel;
    logic [2:0]  fill_word;
    logic [15:0] fill_data;
    logic        tag_we;
    logic [15:0] tag_addr;
    logic        i_done, d_done, d_wr_ack, busy;

    mem_arbiter #(.MEM_LAT(LAT), .BLK_WORDS(BLK)) dut (
        .clk(clk), .rst(rst),
        .i_miss(i_miss), .i_miss_addr(i_miss_addr),
        .d_miss(d_miss), .d_miss_addr(d_miss_addr),
        .d_wr(d_wr), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_valid(mem_valid),
        .fill_we(fill_we), .fill_sel(fill_sel), .fill_word(fill_word), .fill_data(fill_data),
        .tag_we(tag_we), .tag_addr(tag_addr),
        .i_done(i_done), .d_done(d_done), .d_wr_ack(d_wr_ack), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ecnt   = 0;
    int cyc    = 0;

    // model state
    int          op_kind = 0;       // 0 none, 1 write, 2 fill
    int          op_n = 0;
    logic [15:0] op_base = '0, op_wa = '0, op_wd = '0;
    logic        exp_sel = 1'b0;
    int          drain_until = 0;
    int          next_sample = 0;

    // memory model
    int          ret_cyc[$];
    logic [15:0] ret_dat[$];
    logic        junk_force = 1'b0;
    logic        junk_rand  = 1'b0;
    logic        auto_drop  = 1'b1;

    // event bookkeeping
    int cnt_fwe = 0, cnt_idone = 0, cnt_ddone = 0, cnt_ack = 0;
    int t_idone = 0, t_ddone = 0, t_ack = 0, t_ack_first = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic clear_counts();
        cnt_fwe = 0; cnt_idone = 0; cnt_ddone = 0; cnt_ack = 0;
        t_idone = 0; t_ddone = 0; t_ack = 0; t_ack_first = 0;
    endtask

    task automatic tick();
        int e, c, k;
        logic        x_busy, x_en, x_wr, x_fwe, x_tag, x_idone, x_ddone, x_ack;
        logic [15:0] x_addr, x_wdata, x_taddr, x_fdata;
        logic [2:0]  x_fword;
        logic        fill_active;

        // model decision for the coming edge, from the inputs now applied
        e = ecnt + 1;
        if (rst) begin
            op_kind     = 0;
            exp_sel     = 1'b0;
            drain_until = e + LAT;
            next_sample = e + LAT + 1;
        end else if (e == next_sample) begin
            if (d_wr) begin
                op_kind = 1; op_n = e; op_wa = d_wr_addr; op_wd = d_wr_data;
                next_sample = e + 2;
            end else if (d_miss) begin
                op_kind = 2; op_n = e; op_base = d_miss_addr & 16'hFFF0; exp_sel = 1'b1;
                next_sample = e + BLK + LAT + 2;
            end else if (i_miss) begin
                op_kind = 2; op_n = e; op_base = i_miss_addr & 16'hFFF0; exp_sel = 1'b0;
                next_sample = e + BLK + LAT + 2;
            end else begin
                next_sample = e + 1;
            end
        end

        @(posedge clk);
        ecnt++;
        c   = ecnt + 1;
        cyc = c;
        k   = c - op_n;
        #1;

        // memory return or stray strobe for this cycle
        fill_active = (op_kind == 2) && (k >= 1) && (k <= BLK + LAT) && (c > drain_until);
        mem_valid = 1'b0;
        mem_rdata = 16'($urandom);
        if (ret_cyc.size() > 0 && ret_cyc[0] == c) begin
            mem_valid = 1'b1;
            mem_rdata = ret_dat[0];
            void'(ret_cyc.pop_front());
            void'(ret_dat.pop_front());
        end else if (!fill_active && (junk_force || (junk_rand && $urandom_range(3) == 0))) begin
            mem_valid = 1'b1;
        end
        #1;

        // expected outputs for cycle c
        x_busy = 1'b0; x_en = 1'b0; x_wr = 1'b0; x_fwe = 1'b0; x_tag = 1'b0;
        x_idone = 1'b0; x_ddone = 1'b0; x_ack = 1'b0;
        x_addr = '0; x_wdata = '0; x_taddr = '0; x_fdata = '0; x_fword = '0;
        if (c <= drain_until) begin
            x_busy = 1'b1;
        end else if (op_kind == 1 && k == 1) begin
            x_busy = 1'b1; x_en = 1'b1; x_wr = 1'b1; x_ack = 1'b1;
            x_addr = op_wa; x_wdata = op_wd;
        end else if (op_kind == 2 && k >= 1 && k <= BLK + LAT + 1) begin
            x_busy = 1'b1;
            if (k <= BLK) begin
                x_en   = 1'b1;
                x_addr = 16'(op_base + 2 * (k - 1));
            end
            if (k > LAT && k <= LAT + BLK) begin
                x_fwe   = 1'b1;
                x_fword = 3'(k - LAT - 1);
                x_fdata = 16'(16'hA000 + (k - LAT - 1));
            end
            if (k == BLK + LAT + 1) begin
                x_tag   = 1'b1;
                x_taddr = op_base;
                x_idone = !exp_sel;
                x_ddone = exp_sel;
            end
        end

        chk("busy", busy, x_busy);
        chk("mem_en", mem_en, x_en);
        chk("mem_wr", mem_wr, x_wr);
        chk("mem_addr", mem_addr, x_addr);
        chk("mem_wdata", mem_wdata, x_wdata);
        chk("fill_we", fill_we, x_fwe);
        chk("fill_sel", fill_sel, exp_sel);
        chk("fill_word", fill_word, x_fword);
        chk("tag_we", tag_we, x_tag);
        chk("tag_addr", tag_addr, x_taddr);
        chk("i_done", i_done, x_idone);
        chk("d_done", d_done, x_ddone);
        chk("d_wr_ack", d_wr_ack, x_ack);
        if (x_fwe) chk("fill_data", fill_data, x_fdata);

        // memory accepts the read issued this cycle
        if (mem_en === 1'b1 && mem_wr === 1'b0) begin
            ret_cyc.push_back(c + LAT);
            ret_dat.push_back(16'(16'hA000 + mem_addr[3:1]));
        end

        if (fill_we === 1'b1) cnt_fwe++;
        if (i_done === 1'b1) begin
            cnt_idone++; t_idone = c;
            if (auto_drop) i_miss = 1'b0;
        end
        if (d_done === 1'b1) begin
            cnt_ddone++; t_ddone = c;
            if (auto_drop) d_miss = 1'b0;
        end
        if (d_wr_ack === 1'b1) begin
            cnt_ack++; t_ack = c;
            if (cnt_ack == 1) t_ack_first = c;
            if (auto_drop) d_wr = 1'b0;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int grant;

        // reset and drain with stray strobes
        rst = 1'b1;
        tick();
        junk_force = 1'b1;
        tick();
        rst = 1'b0;
        clear_counts();
        run(3);
        junk_force = 1'b0;
        chk("drain_busy", busy, 1'b1);
        tick();
        chk("drain_idle_busy", busy, 1'b0);
        chk("drain_no_fill", cnt_fwe, 0);

        // I fill at 0x0046
        clear_counts();
        i_miss = 1'b1; i_miss_addr = 16'h0046;
        tick();
        grant = op_n;
        run(16);
        chk("ifill_fwe_cnt", cnt_fwe, BLK);
        chk("ifill_done_cnt", cnt_idone, 1);
        chk("ifill_done_lat", t_idone - grant, BLK + LAT + 1);

        // priority: write, then D fill, then I fill
        clear_counts();
        d_wr = 1'b1; d_wr_addr = 16'h2000; d_wr_data = 16'hBEEF;
        d_miss = 1'b1; d_miss_addr = 16'h3000;
        i_miss = 1'b1; i_miss_addr = 16'h0100;
        run(34);
        chk("prio_ack_cnt", cnt_ack, 1);
        chk("prio_ddone_cnt", cnt_ddone, 1);
        chk("prio_idone_cnt", cnt_idone, 1);
        chk("prio_order", (t_ack < t_ddone) && (t_ddone < t_idone), 1'b1);

        // reset in the middle of a fill
        clear_counts();
        i_miss = 1'b1; i_miss_addr = 16'h0200;
        for (int i = 0; i < 20 && cnt_fwe < 3; i++) tick();
        chk("midrst_reached_3rd", cnt_fwe, 3);
        rst = 1'b1; i_miss = 1'b0;
        tick();
        rst = 1'b0;
        run(6);
        chk("midrst_fwe_cnt", cnt_fwe, 3);
        chk("midrst_no_done", cnt_idone, 0);
        clear_counts();
        i_miss = 1'b1; i_miss_addr = 16'h0080;
        run(16);
        chk("midrst_refill_fwe", cnt_fwe, BLK);
        chk("midrst_refill_done", cnt_idone, 1);

        // wrap block and request dropped mid-fill
        clear_counts();
        d_miss = 1'b1; d_miss_addr = 16'hFFF8;
        run(2);
        d_miss = 1'b0; d_miss_addr = 16'h1234;
        run(14);
        chk("wrap_fwe_cnt", cnt_fwe, BLK);
        chk("wrap_done_cnt", cnt_ddone, 1);

        // back-to-back writes from a held d_wr
        clear_counts();
        auto_drop = 1'b0;
        d_wr = 1'b1; d_wr_addr = 16'h4444; d_wr_data = 16'h1357;
        run(3);
        d_wr = 1'b0;
        run(4);
        auto_drop = 1'b1;
        chk("b2b_ack_cnt", cnt_ack, 2);
        chk("b2b_ack_gap", t_ack - t_ack_first, 2);

        // randomized traffic, stray strobes and occasional reset
        junk_rand = 1'b1;
        for (int i = 0; i < 500; i++) begin
            if (!d_wr && $urandom_range(7) == 0) begin
                d_wr = 1'b1; d_wr_addr = 16'($urandom); d_wr_data = 16'($urandom);
            end
            if (!d_miss && $urandom_range(5) == 0) begin
                d_miss = 1'b1; d_miss_addr = 16'($urandom);
            end
            if (!i_miss && $urandom_range(3) == 0) begin
                i_miss = 1'b1; i_miss_addr = 16'($urandom);
            end
            if ($urandom_range(7) == 0) i_miss_addr = 16'($urandom);
            if ($urandom_range(7) == 0) d_miss_addr = 16'($urandom);
            rst = ($urandom_range(149) == 0);
            tick();
        end
        rst = 1'b0;
        junk_rand = 1'b0;
        run(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the single shared main-memory port between the I-cache miss path (IF stage) and the D-cache miss and write-through path (MEM stage) of the pipelined cpu.
- On a miss, it grants one requester and fetches a full 16-byte block (8 words) with pipelined reads, streaming the words into that cache's data array.
- It then pulses tag-write and done so the stalled stage can resume.
- It also issues single-word D-side writes.

Parameters:
- MEM_LAT, 4, cycles from a read issue (mem_en=1, mem_wr=0) to its mem_valid.
- BLK_WORDS, 8, 16-bit words per cache block; a power of 2.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- i_miss  in  1  I-cache miss request; level, held until i_done
- i_miss_addr  in  16  byte address of the I miss
- d_miss  in  1  D-cache miss request; level, held until d_done
- d_miss_addr  in  16  byte address of the D miss
- d_wr  in  1  D write-through request; level, dropped on d_wr_ack
- d_wr_addr  in  16  byte address for the write
- d_wr_data  in  16  write data
- mem_en  out  1  memory access strobe
- mem_wr  out  1  1 = write, 0 = read
- mem_addr  out  16  memory byte address
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  read data; valid when mem_valid=1
- mem_valid  in  1  read data return strobe
- fill_we  out  1  write fill_data into the selected cache data array
- fill_sel  out  1  0 = I-cache, 1 = D-cache
- fill_word  out  3  word index within the block (log2 BLK_WORDS bits)
- fill_data  out  16  equals mem_rdata
- tag_we  out  1  write the tag/valid entry for the block at tag_addr
- tag_addr  out  16  block base address
- i_done  out  1  one-cycle pulse, I fill complete
- d_done  out  1  one-cycle pulse, D fill complete
- d_wr_ack  out  1  one-cycle pulse, write issued
- busy  out  1  1 in any state other than IDLE

Behaviour:
- States: DRAIN, IDLE, WRITE, FILL, DONE.
- Outputs are Moore-decoded from registered state and counters. Exceptions: fill_data = mem_rdata, and fill_we = (state==FILL) & mem_valid.
- Reset (rst=1 at a clock edge):
  - state becomes DRAIN and drain_cnt = MEM_LAT.
  - All outputs are 0 except busy=1; fill_data still follows mem_rdata.
  - This applies mid-fill or mid-write: no done or ack is issued for the aborted operation.
- DRAIN:
  - Decrement each cycle; go to IDLE when the count reaches 0.
  - mem_valid is ignored, which discards read returns still in flight from before reset.
  - Requests are not sampled.
- IDLE: sample requests at each edge. Fixed priority is d_wr > d_miss > i_miss.
  - The winning request's address is latched. Block base = addr & 16'hFFF0.
  - fill_sel is latched: 1 for d_miss, 0 for i_miss.
- WRITE, exactly 1 cycle:
  - mem_en=1, mem_wr=1, mem_addr and mem_wdata from the latched values, d_wr_ack=1.
  - Next state is IDLE.
  - If d_wr is still 1 at the following IDLE edge, it is treated as a new write.
- FILL:
  - issue_cnt runs 0..BLK_WORDS-1. In each of the first BLK_WORDS FILL cycles: mem_en=1, mem_wr=0, mem_addr = base + 2*issue_cnt.
  - After that, mem_en=0 while waiting.
  - recv_cnt advances on each mem_valid; fill_word = recv_cnt.
  - When the last word is received (recv_cnt==BLK_WORDS-1 & mem_valid), go to DONE.
- DONE, 1 cycle:
  - tag_we=1 and tag_addr = base.
  - i_done=1 or d_done=1 according to fill_sel.
  - Next state is IDLE.
- Latency, request sampled in IDLE at edge N:
  - Issues occur in cycles N+1..N+BLK_WORDS.
  - Data returns in cycles N+1+MEM_LAT..N+BLK_WORDS+MEM_LAT.
  - DONE is cycle N+BLK_WORDS+MEM_LAT+1.
  - With defaults: fill_we in cycles N+5..N+12, done at N+13, new sample at edge N+14.
- Writes: 2 cycles from sample back to IDLE.
- Boundaries:
  - A request dropped mid-fill does not abort it: the fill and the done pulse still occur.
  - A request that changes address mid-fill is ignored; the latched base is used.
  - Simultaneous d_wr, d_miss and i_miss are served write, then D fill, then I fill, in consecutive grants. I can starve only while the D side keeps requesting.
  - mem_valid in IDLE or WRITE is ignored.
  - A base of 16'hFFF0 issues FFF0..FFFE; no carry beyond the block.
  - Unaligned miss addresses (e.g. 0x1237) fetch their aligned block (0x1230).

Test Plan:
- Reset and drain: assert rst for 2 cycles, pulse mem_valid=1 during the 4 drain cycles -> busy=1, no fill_we; IDLE and busy=0 on the 5th cycle after release.
- I fill: i_miss=1 with addr 0x0046, memory returns 0xA000+word -> mem_addr 0x0040..0x004E in cycles N+1..N+8, fill_we with fill_word 0..7 and data A000..A007 in N+5..N+12, fill_sel=0, tag_we=1 with tag_addr 0x0040 and i_done=1 at N+13.
- Priority: d_wr (addr 0x2000, data 0xBEEF), d_miss 0x3000 and i_miss 0x0100 all asserted together -> WRITE with mem_wr=1 and d_wr_ack, then D fill ending in d_done, then I fill ending in i_done; no overlap of mem_en phases.
- Reset mid-fill: rst for 1 cycle during the 3rd fill_we -> no done pulse, returns still in flight produce no fill_we, then a new i_miss 0x0080 fills cleanly with fill_word starting at 0.
- Wrap and drop: d_miss 0xFFF8 dropped after 2 cycles -> reads 0xFFF0..0xFFFE, all 8 fill_we, d_done still pulses.
- Back-to-back write: d_wr held for 3 cycles -> two acks, at N+1 and N+3.
